ex_muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit in the EX stage, fed directly by the ID->EX pipeline register
//  (operands RD1_E/RD2_E after forwarding). Executes MULT/MULTU/DIV/DIVU over multiple cycles

---
 rtl/ex_muldiv_unit.sv | 197 +++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative multiply/divide unit for the EX stage.
// MULT/MULTU use radix-2 shift-add and DIV/DIVU use restoring shift-subtract.
// Both work on operand magnitudes, one bit per cycle. The sign fix-up happens in
// a single FIX cycle, and the result lands in the private HI/LO registers.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] SrcA_E,
  input  logic [WIDTH-1:0] SrcB_E,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, next_state;

  // Two's-complement negate when neg is set, used for magnitudes and sign fix-up
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + ONE_W) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + ONE_2W) : v;
  endfunction

  logic [CNT_W-1:0] cnt;

  // Latched at start
  logic             is_div;
  logic             neg_res;     // product / quotient must be negated
  logic             neg_rem;     // remainder must be negated (dividend negative)
  logic             div_zero;
  logic [WIDTH-1:0] a_raw;       // raw dividend, returned in HI on divide by zero
  logic [WIDTH-1:0] opnd;        // multiplicand magnitude or divisor magnitude

  // Iteration state: MUL {acc_hi,acc_lo} = partial product / multiplier,
  // DIV acc_hi = partial remainder, acc_lo = dividend shifting into quotient
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  // Start-cycle operand conditioning
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic                    is_signed_op;
  logic                    a_neg;
  logic                    b_neg;
  logic [WIDTH-1:0]        mag_a;
  logic [WIDTH-1:0]        mag_b;

  assign a_s          = SrcA_E;
  assign b_s          = SrcB_E;
  assign is_signed_op = ~op[0];
  assign a_neg        = is_signed_op & a_s[WIDTH-1];
  assign b_neg        = is_signed_op & b_s[WIDTH-1];
  assign mag_a        = cond_neg(SrcA_E, a_neg);
  assign mag_b        = cond_neg(SrcB_E, b_neg);

  // Per-iteration arithmetic
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] div_rem;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign div_diff  = div_shift[WIDTH-1:0] - opnd;
  assign div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];

  // Sign fix-up and final result selection
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign prod_fix = cond_neg2({acc_hi, acc_lo}, neg_res);

  logic hilo_wr_ok;
  assign hilo_wr_ok = ((state == S_IDLE) && !start) || (state == S_DONE);

  // Select the signed, corrected result written to HI/LO in FIX
  always_comb begin
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        fix_hi = a_raw;
        fix_lo = '1;
      end else begin
        fix_hi = cond_neg(acc_hi, neg_rem);
        fix_lo = cond_neg(acc_lo, neg_res);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state and status outputs
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) next_state = op[1] ? S_DIV : S_MUL;
      end
      S_MUL: begin
        busy = 1'b1;
        if (cnt == '0) next_state = S_FIX;
      end
      S_DIV: begin
        busy = 1'b1;
        if (cnt == '0) next_state = S_FIX;
      end
      S_FIX: begin
        busy       = 1'b1;
        next_state = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Iteration counter: WIDTH steps, from WIDTH-1 down to 0
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if ((state == S_IDLE) && start) begin
      cnt <= CNT_INIT;
    end else if (((state == S_MUL) || (state == S_DIV)) && (cnt != '0)) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  // Operand latch at start, then one shift-add or shift-subtract step per cycle
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && start) begin
      is_div   <= op[1];
      neg_res  <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      div_zero <= (SrcB_E == '0);
      a_raw    <= SrcA_E;
      opnd     <= op[1] ? mag_b : mag_a;
      acc_hi   <= '0;
      acc_lo   <= op[1] ? mag_a : mag_b;
    end else if (state == S_MUL) begin
      acc_hi   <= mul_sum[WIDTH:1];
      acc_lo   <= {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else if (state == S_DIV) begin
      acc_hi   <= div_rem;
      acc_lo   <= {acc_lo[WIDTH-2:0], div_ge};
    end
  end

  // HI/LO: result written at the FIX->DONE edge, MTHI/MTLO only when not busy
  always_ff @(posedge clk) begin
    if (reset) begin
      HI <= '0;
      LO <= '0;
    end else if (state == S_FIX) begin
      HI <= fix_hi;
      LO <= fix_lo;
    end else if (hilo_wr_ok) begin
      if (hi_we) HI <= SrcA_E;
      if (lo_we) LO <= SrcA_E;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed vector table plus hand sequences for reset,
// ignored start/writes while busy, MTHI/MTLO and DONE-cycle behaviour.
module tb_ex_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] SrcA_E;
  logic [W-1:0] SrcB_E;
  logic         hi_we;
  logic         lo_we;
  logic         busy;
  logic         done;
  logic [W-1:0] HI;
  logic [W-1:0] LO;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .SrcA_E (SrcA_E),
    .SrcB_E (SrcB_E),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .busy   (busy),
    .done   (done),
    .HI     (HI),
    .LO     (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launch: start sampled at the next posedge (edge 0); returns at the cycle-1
  // sample point with the operand buses scrambled.
  task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; op = o; SrcA_E = a; SrcB_E = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op = ~o; SrcA_E = ~a; SrcB_E = a ^ b;
  endtask

  // Waits for done, bounded; busy must stay high until done.
  task automatic wait_done(input int cyc0, output int cyc, output bit busy_ok);
    cyc = cyc0;
    busy_ok = 1'b1;
    while (!done && cyc < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int  cyc;
    bit  bok;
    bit  seen;

    vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{2'b10, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
    vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[7]  = '{2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[8]  = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[9]  = '{2'b11, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
    vecs[10] = '{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[11] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[12] = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
    vecs[13] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    vecs[14] = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[15] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
    vecs[16] = '{2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};

    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; SrcA_E = '0; SrcB_E = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_hi", 64'(HI), 64'(0));
    check("reset_lo", 64'(LO), 64'(0));
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(1, cyc, bok);
      check($sformatf("v%0d_done_cycle", i), 64'(cyc), 64'(34));
      check($sformatf("v%0d_busy_held", i), 64'(bok), 64'(1));
      check($sformatf("v%0d_hi", i), 64'(HI), 64'(vecs[i].hi));
      check($sformatf("v%0d_lo", i), 64'(LO), 64'(vecs[i].lo));
      @(negedge clk);
      check($sformatf("v%0d_pulse_end", i), 64'({done, busy}), 64'(0));
    end

    // Reset in the middle of a MULT
    start_op(2'b00, 32'h00000005, 32'h00000006);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midop_reset_busy", 64'(busy), 64'(0));
    check("midop_reset_done", 64'(done), 64'(0));
    check("midop_reset_hi", 64'(HI), 64'(0));
    check("midop_reset_lo", 64'(LO), 64'(0));
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("midop_reset_no_done", 64'(seen), 64'(0));

    // start and MTHI/MTLO while busy are ignored
    start_op(2'b11, 32'h00000064, 32'h00000007);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b01; SrcA_E = 32'hDEADBEEF; SrcB_E = 32'h00000003;
    lo_we = 1'b1; hi_we = 1'b1;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
    check("busy_write_lo", 64'(LO), 64'(0));
    check("busy_write_hi", 64'(HI), 64'(0));
    wait_done(6, cyc, bok);
    check("busy_start_cycle", 64'(cyc), 64'(34));
    check("busy_start_hi", 64'(HI), 64'(32'h00000002));
    check("busy_start_lo", 64'(LO), 64'(32'h0000000E));
    @(negedge clk);

    // MTLO alone, then MTHI+MTLO together, in IDLE
    lo_we = 1'b1; SrcA_E = 32'hCAFEBABE;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_lo", 64'(LO), 64'(32'hCAFEBABE));
    check("mtlo_hi_kept", 64'(HI), 64'(32'h00000002));
    hi_we = 1'b1; lo_we = 1'b1; SrcA_E = 32'h11223344;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthilo_hi", 64'(HI), 64'(32'h11223344));
    check("mthilo_lo", 64'(LO), 64'(32'h11223344));

    // start and MTLO in the same IDLE cycle: start wins
    start = 1'b1; op = 2'b01; SrcA_E = 32'h00000002; SrcB_E = 32'h00000003; lo_we = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    check("same_cycle_lo_dropped", 64'(LO), 64'(32'h11223344));
    check("same_cycle_busy", 64'(busy), 64'(1));
    wait_done(1, cyc, bok);
    check("same_cycle_cycle", 64'(cyc), 64'(34));
    check("same_cycle_hi", 64'(HI), 64'(0));
    check("same_cycle_lo", 64'(LO), 64'(32'h00000006));

    // In DONE: start ignored, MTHI honoured
    start = 1'b1; op = 2'b00; SrcA_E = 32'hABCD0123; SrcB_E = 32'h00000005; hi_we = 1'b1;
    @(negedge clk);
    check("done_start_ignored", 64'(busy), 64'(0));
    check("done_mthi_hi", 64'(HI), 64'(32'hABCD0123));
    check("done_mthi_lo_kept", 64'(LO), 64'(32'h00000006));
    start = 1'b0; hi_we = 1'b0;
    @(negedge clk);
    check("done_still_idle", 64'({busy, done}), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
